// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Wide enough to index up to 8 data bits or 2 stop bits.
  localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/baud_down_counter.sv
// Reloadable down-counter that marks the end of each serial bit period.
module baud_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // Load wins over decrement; the count parks at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, data (LSB first), optional parity and stop bits.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 done
);

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  uart_tx_state_t         state, next_state;
  logic [DATA_BITS-1:0]   shift;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   par_bit;
  logic [DIV_W-1:0]       div_reg;
  logic [DIV_W-1:0]       eff_div;
  logic [DIV_W-1:0]       load_val;
  logic [DIV_W-1:0]       cnt;
  logic                   zero;
  logic                   accept;
  logic                   bit_end;
  logic                   load;
  logic                   unused_cnt;

  assign accept     = tx_valid && (state == ST_IDLE);
  assign bit_end    = (state != ST_IDLE) && zero;
  assign eff_div    = (baud_div == '0) ? DIV_W'(1) : baud_div;
  assign load       = accept || bit_end;
  assign load_val   = accept ? (eff_div - DIV_W'(1)) : (div_reg - DIV_W'(1));
  assign unused_cnt = ^cnt;

  baud_down_counter #(.W(DIV_W)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .cnt      (cnt),
    .zero     (zero)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (tx_valid) next_state = ST_START;
      ST_START:  if (zero) next_state = ST_DATA;
      ST_DATA:
        if (zero && bit_cnt == LAST_DATA)
          next_state = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (zero) next_state = ST_STOP;
      ST_STOP:   if (zero && bit_cnt == LAST_STOP) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_out   = 1'b1;
    tx_ready = 1'b0;
    busy     = 1'b1;
    case (state)
      ST_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_START:  tx_out = 1'b0;
      ST_DATA:   tx_out = shift[0];
      ST_PARITY: tx_out = par_bit;
      default:   tx_out = 1'b1;
    endcase
  end

  // Parity is fixed at accept time so later tx_data changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      div_reg <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == ST_STOP) && zero && (bit_cnt == LAST_STOP);
      if (accept) begin
        shift   <= tx_data;
        div_reg <= eff_div;
        par_bit <= (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
        bit_cnt <= '0;
      end else if (bit_end) begin
        case (state)
          ST_DATA: begin
            shift   <= shift >> 1;
            bit_cnt <= (bit_cnt == LAST_DATA) ? '0 : bit_cnt + BIT_CNT_W'(1);
          end
          ST_STOP: bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          default: bit_cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench: three parity/stop configurations driven in lockstep and
// compared against a per-cycle waveform model of the serial frame.
module tb_uart_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic [2:0]  tx_ready, tx_out, busy, done;

  int n_asserts = 0;
  int n_fail    = 0;
  int cur_t     = 0;
  int par_p[3]  = '{0, 1, 2};
  int stop_p[3] = '{1, 2, 2};

  always #5 clk = ~clk;

  uart_tx_ctrl dut0 (
    .clk(clk), .rst(rst), .baud_div(baud_div), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready[0]), .tx_out(tx_out[0]), .busy(busy[0]), .done(done[0]));

  uart_tx_ctrl #(.PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .baud_div(baud_div), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready[1]), .tx_out(tx_out[1]), .busy(busy[1]), .done(done[1]));

  uart_tx_ctrl #(.PARITY(2), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .baud_div(baud_div), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready[2]), .tx_out(tx_out[2]), .busy(busy[2]), .done(done[2]));

  function automatic int frame_len(int idx, int div);
    return (1 + 8 + ((par_p[idx] != 0) ? 1 : 0) + stop_p[idx]) * div;
  endfunction

  // Expected line level t cycles after the accept edge (t >= 1).
  function automatic logic exp_tx(int idx, logic [7:0] d, int div, int t);
    int f;
    int b;
    f = frame_len(idx, div);
    if (t < 1 || t > f) return 1'b1;
    b = (t - 1) / div;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (par_p[idx] != 0 && b == 9) return (par_p[idx] == 1) ? ^d : ~^d;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input int idx, input logic obs, input logic expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s dut%0d t=%0d: observed %b expected %b", tag, idx, cur_t, obs, expv);
    end
  endtask

  task automatic check_idle(input int idx);
    check("idle_tx", idx, tx_out[idx], 1'b1);
    check("idle_ready", idx, tx_ready[idx], 1'b1);
    check("idle_busy", idx, busy[idx], 1'b0);
    check("idle_done", idx, done[idx], 1'b0);
  endtask

  task automatic check_frame_cycle(input int idx, input logic [7:0] d, input int div, input int t);
    int f;
    f = frame_len(idx, div);
    check("tx_out", idx, tx_out[idx], exp_tx(idx, d, div, t));
    check("done", idx, done[idx], t == f + 1);
    check("busy", idx, busy[idx], t >= 1 && t <= f);
    check("tx_ready", idx, tx_ready[idx], t > f);
  endtask

  // Offer one byte to all three controllers and follow every cycle until all are idle.
  task automatic run_frame(input logic [7:0] d, input int div_in);
    int div;
    div = (div_in == 0) ? 1 : div_in;
    @(negedge clk);
    baud_div = 16'(div_in);
    tx_data  = d;
    tx_valid = 1'b1;
    for (int t = 1; t <= 12 * div + 2; t++) begin
      @(negedge clk);
      cur_t = t;
      if (t == 1) tx_valid = 1'b0;
      for (int i = 0; i < 3; i++) check_frame_cycle(i, d, div, t);
    end
  endtask

  initial begin
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    baud_div = 16'd4;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      cur_t = t;
      for (int i = 0; i < 3; i++) check_idle(i);
    end

    run_frame(8'hA5, 4);
    run_frame(8'h07, 3);
    run_frame(8'hFF, 0);
    for (int n = 0; n < 8; n++)
      run_frame(8'($urandom), int'($urandom_range(0, 4)));

    // Back-to-back with divisor 0: second accept lands on the done cycle.
    @(negedge clk);
    baud_div = 16'd0;
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      cur_t = t;
      for (int i = 0; i < 3; i++)
        if (t <= 10 || i != 0) check_frame_cycle(i, 8'hFF, 1, t);
      if (t == 11) begin
        check("b2b_done", 0, done[0], 1'b1);
        check("b2b_ready", 0, tx_ready[0], 1'b1);
        check("b2b_idle_gap", 0, tx_out[0], 1'b1);
      end
      if (t == 12) begin
        check("b2b_start", 0, tx_out[0], 1'b0);
        check("b2b_busy", 0, busy[0], 1'b1);
        tx_valid = 1'b0;
      end
    end

    // Reset alongside a valid request: nothing may be accepted.
    rst      = 1'b1;
    tx_valid = 1'b1;
    @(negedge clk);
    cur_t = 0;
    for (int i = 0; i < 3; i++) check_idle(i);
    rst      = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle(i);

    // Mid-frame input changes are ignored; reset truncates the frame.
    baud_div = 16'd5;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      cur_t = t;
      if (t == 1) tx_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (t <= 20) begin
          check("mid_tx", i, tx_out[i], exp_tx(i, 8'h3C, 5, t));
          check("mid_busy", i, busy[i], 1'b1);
          check("mid_done", i, done[i], 1'b0);
        end else begin
          check_idle(i);
        end
      end
      if (t == 12) begin
        baud_div = 16'd2;
        tx_data  = 8'h00;
      end
      if (t == 20) rst = 1'b1;
      if (t == 21) rst = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
